// File: rtl/axi_mem_slave_if.sv
// rtl/axi_mem_slave_if.sv - AXI4 bus bundle between the L2 master port and axi_mem_slave
interface axi_mem_slave_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 256
);
    logic                awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic                bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic                arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic                rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/axi_mem_slave.sv
// rtl/axi_mem_slave.sv - AXI4 INCR burst responder backed by single-port on-chip RAM
module axi_mem_slave #(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 256,
    parameter int MEM_ADDR_W = 12
) (
    input  logic           clk,
    input  logic           rst,
    axi_mem_slave_if.slave axi
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, READ} state_t;

    state_t                state_q, state_d;
    logic                  id_q, id_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  prio_wr_q, prio_wr_d;
    logic                  infl_q, infl_d;
    logic                  infl_last_q, infl_last_d;
    logic [1:0]            fcnt_q, fcnt_d;
    logic [DATA_W-1:0]     buf0_q, buf0_d, buf1_q, buf1_d;
    logic                  last0_q, last0_d, last1_q, last1_d;

    logic [DATA_W-1:0]     mem [2**MEM_ADDR_W];
    logic [DATA_W-1:0]     ram_q;
    logic [MEM_ADDR_W-1:0] ram_addr;
    logic                  ram_we;

    logic                  aw_go, ar_go, rvalid, pop, space, issue, issue_last;
    logic [1:0]            base;
    logic [MEM_ADDR_W-1:0] aw_word, ar_word;
    logic                  unused_ok;

    assign aw_word = axi.awaddr[OFF_W +: MEM_ADDR_W];
    assign ar_word = axi.araddr[OFF_W +: MEM_ADDR_W];
    assign aw_go   = axi.awvalid && (!axi.arvalid || prio_wr_q);
    assign ar_go   = axi.arvalid && !aw_go;
    assign rvalid  = (fcnt_q != 2'd0);
    assign pop     = rvalid && axi.rready;
    // Reads in flight plus buffered beats never exceed the two skid slots.
    assign space   = ((3'(fcnt_q) + 3'(infl_q)) < 3'd2) || pop;

    assign axi.awready = (state_q == IDLE) && aw_go;
    assign axi.arready = (state_q == IDLE) && ar_go;
    assign axi.wready  = (state_q == WDATA);
    assign axi.bvalid  = (state_q == WRESP);
    assign axi.bid     = id_q;
    assign axi.bresp   = 2'b00;
    assign axi.rid     = id_q;
    assign axi.rresp   = 2'b00;
    assign axi.rdata   = buf0_q;
    assign axi.rvalid  = rvalid;
    assign axi.rlast   = last0_q && rvalid;

    assign unused_ok = ^{axi.awsize, axi.awburst, axi.arsize, axi.arburst, axi.wlast,
                         axi.awaddr, axi.araddr};

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        prio_wr_d  = prio_wr_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = addr_q;
        case (state_q)
            IDLE: begin
                // Priority only flips when both channels compete, so contested pairs alternate.
                if (aw_go) begin
                    state_d = WDATA;
                    id_d    = axi.awid;
                    addr_d  = aw_word;
                    cnt_d   = axi.awlen;
                    if (axi.arvalid) prio_wr_d = 1'b0;
                end else if (ar_go) begin
                    state_d    = READ;
                    id_d       = axi.arid;
                    ram_addr   = ar_word;
                    issue      = 1'b1;
                    issue_last = (axi.arlen == 8'd0);
                    addr_d     = ar_word + MEM_ADDR_W'(1);
                    cnt_d      = axi.arlen;
                    if (axi.awvalid) prio_wr_d = 1'b1;
                end
            end
            WDATA: begin
                if (axi.wvalid) begin
                    ram_we = 1'b1;
                    addr_d = addr_q + MEM_ADDR_W'(1);
                    cnt_d  = cnt_q - 8'd1;
                    if (cnt_q == 8'd0) state_d = WRESP;
                end
            end
            WRESP: begin
                if (axi.bready) state_d = IDLE;
            end
            default: begin
                // cnt_q counts RAM reads still to issue after the first one.
                if ((cnt_q != 8'd0) && space) begin
                    issue      = 1'b1;
                    issue_last = (cnt_q == 8'd1);
                    addr_d     = addr_q + MEM_ADDR_W'(1);
                    cnt_d      = cnt_q - 8'd1;
                end
                if (pop && last0_q) state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        infl_d      = issue;
        infl_last_d = issue_last;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        last0_d     = last0_q;
        last1_d     = last1_q;
        if (pop) begin
            buf0_d  = buf1_q;
            last0_d = last1_q;
        end
        base = fcnt_q - {1'b0, pop};
        if (infl_q) begin
            if (base == 2'd0) begin
                buf0_d  = ram_q;
                last0_d = infl_last_q;
            end else begin
                buf1_d  = ram_q;
                last1_d = infl_last_q;
            end
        end
        fcnt_d = base + {1'b0, infl_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            id_q        <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= 8'd0;
            prio_wr_q   <= 1'b1;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            fcnt_q      <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            prio_wr_q   <= prio_wr_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            fcnt_q      <= fcnt_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            last0_q     <= last0_d;
            last1_q     <= last1_d;
        end
    end

    // RAM has no reset so its contents survive an aborted burst.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi.wstrb[b]) mem[ram_addr][b*8 +: 8] <= axi.wdata[b*8 +: 8];
            end
        end
        ram_q <= mem[ram_addr];
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb/tb_axi_mem_slave.sv - scoreboard bench for axi_mem_slave
module tb_axi_mem_slave;
    localparam int ADDR_W     = 30;
    localparam int DATA_W     = 256;
    localparam int MEM_ADDR_W = 12;
    localparam int OFF_W      = 5;
    localparam int DEPTH      = 1 << MEM_ADDR_W;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              id;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [DATA_W-1:0] model [int];
    beat_t exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_mem_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();
    axi_mem_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_ADDR_W(MEM_ADDR_W)) dut (
        .clk(clk),
        .rst(rst),
        .axi(axi)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] beat_data(input int mode, input int i);
        logic [DATA_W-1:0] d;
        case (mode)
            0:       d = {32{8'hA5}};
            1:       d = DATA_W'(i);
            default: d = {{4{32'h5A00_0000 + 32'(mode)}}, {4{32'(i) ^ 32'h00C3_0000}}};
        endcase
        return d;
    endfunction

    function automatic logic [DATA_W/8-1:0] beat_strb(input int mode, input int i);
        return (mode == 1 && (i % 2) == 1) ? 32'h0000_000F : '1;
    endfunction

    function automatic void model_write(input int word, input logic [DATA_W-1:0] d,
                                        input logic [DATA_W/8-1:0] s);
        logic [DATA_W-1:0] m;
        m = model.exists(word) ? model[word] : '0;
        for (int b = 0; b < DATA_W/8; b++) if (s[b]) m[b*8 +: 8] = d[b*8 +: 8];
        model[word] = m;
    endfunction

    task automatic check_w(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic aw_drive(input logic id, input logic [ADDR_W-1:0] addr, input int len);
        axi.awid = id; axi.awaddr = addr; axi.awlen = 8'(len);
        axi.awsize = 3'd5; axi.awburst = 2'b01; axi.awvalid = 1'b1;
    endtask

    task automatic ar_drive(input logic id, input logic [ADDR_W-1:0] addr, input int len);
        axi.arid = id; axi.araddr = addr; axi.arlen = 8'(len);
        axi.arsize = 3'd5; axi.arburst = 2'b01; axi.arvalid = 1'b1;
    endtask

    task automatic aw_accept(output int hs);
        int n;
        n = 0;
        #1;
        while (axi.awready !== 1'b1 && n < 300) begin @(negedge clk); #1; n++; end
        check_b("aw_accept", axi.awready, 1'b1);
        hs = cyc;
        @(negedge clk);
        axi.awvalid = 1'b0;
    endtask

    task automatic ar_accept(output int hs);
        int n, word, len;
        beat_t b;
        n = 0;
        #1;
        while (axi.arready !== 1'b1 && n < 300) begin @(negedge clk); #1; n++; end
        check_b("ar_accept", axi.arready, 1'b1);
        hs   = cyc;
        word = int'(axi.araddr[OFF_W +: MEM_ADDR_W]);
        len  = int'(axi.arlen);
        for (int i = 0; i <= len; i++) begin
            b.data = model[(word + i) % DEPTH];
            b.last = (i == len);
            b.id   = axi.arid;
            exp_q.push_back(b);
        end
        @(negedge clk);
        axi.arvalid = 1'b0;
    endtask

    task automatic w_phase(input logic [ADDR_W-1:0] addr, input int len, input int mode,
                           input int abort_beat, input logic id);
        int word, n;
        word = int'(addr[OFF_W +: MEM_ADDR_W]);
        for (int i = 0; i <= len; i++) begin
            n = 0;
            axi.wvalid = 1'b1;
            axi.wdata  = beat_data(mode, i);
            axi.wstrb  = beat_strb(mode, i);
            axi.wlast  = (i == len);
            if (i == abort_beat) begin
                rst = 1'b0;
                #1;
                check_b("rst_awready", axi.awready, 1'b0);
                check_b("rst_arready", axi.arready, 1'b0);
                check_b("rst_wready", axi.wready, 1'b0);
                check_b("rst_bvalid", axi.bvalid, 1'b0);
                check_b("rst_rvalid", axi.rvalid, 1'b0);
                @(negedge clk);
                axi.wvalid = 1'b0;
                rst = 1'b1;
                return;
            end
            #1;
            if (i == 0) check_b("wready_at_aw_plus1", axi.wready, 1'b1);
            while (axi.wready !== 1'b1 && n < 300) begin @(negedge clk); #1; n++; end
            check_b("w_accept", axi.wready, 1'b1);
            model_write((word + i) % DEPTH, axi.wdata, axi.wstrb);
            @(negedge clk);
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
        #1;
        check_b("bvalid_at_last_plus1", axi.bvalid, 1'b1);
        check_b("bid_echo", axi.bid, id);
        check_w("bresp_okay", DATA_W'(axi.bresp), '0);
        @(negedge clk);
        #1;
        check_b("b_retired", axi.bvalid, 1'b0);
    endtask

    task automatic r_phase(input int hs, input int nbeats, input int stall);
        int got, n, first;
        logic held_v, held_l;
        logic [DATA_W-1:0] held_d;
        beat_t e;
        got = 0; n = 0; first = -1; held_v = 1'b0; held_l = 1'b0; held_d = '0;
        while (got < nbeats && n < 3000) begin
            axi.rready = (stall == 0) || ((n % 3) == 0);
            #1;
            if (held_v) begin
                check_b("r_hold_valid", axi.rvalid, 1'b1);
                check_w("r_hold_data", axi.rdata, held_d);
                check_b("r_hold_last", axi.rlast, held_l);
            end
            held_v = 1'b0;
            if (axi.rvalid === 1'b1) begin
                if (first < 0) begin
                    first = cyc;
                    check_w("r_first_latency", DATA_W'(first - hs), DATA_W'(2));
                end
                if (axi.rready) begin
                    e = exp_q.pop_front();
                    check_w("r_data", axi.rdata, e.data);
                    check_b("r_last", axi.rlast, e.last);
                    check_b("r_id", axi.rid, e.id);
                    check_w("r_resp", DATA_W'(axi.rresp), '0);
                    got++;
                end else begin
                    held_v = 1'b1;
                    held_d = axi.rdata;
                    held_l = axi.rlast;
                end
            end
            @(negedge clk);
            n++;
        end
        axi.rready = 1'b1;
        check_w("r_beat_count", DATA_W'(got), DATA_W'(nbeats));
        check_w("sb_drained", DATA_W'(exp_q.size()), '0);
        #1;
        check_b("r_no_extra", axi.rvalid, 1'b0);
    endtask

    task automatic write_burst(input logic id, input logic [ADDR_W-1:0] addr, input int len, input int mode);
        int hs;
        @(negedge clk);
        aw_drive(id, addr, len);
        aw_accept(hs);
        w_phase(addr, len, mode, -1, id);
    endtask

    task automatic read_burst(input logic id, input logic [ADDR_W-1:0] addr, input int len, input int stall);
        int hs;
        @(negedge clk);
        ar_drive(id, addr, len);
        ar_accept(hs);
        r_phase(hs, len + 1, stall);
    endtask

    initial begin
        int hs;
        axi.awid = 1'b0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
        axi.bready = 1'b1; axi.arid = 1'b0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0;
        axi.arburst = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_b("reset_awready", axi.awready, 1'b0);
        check_b("reset_arready", axi.arready, 1'b0);
        check_b("reset_wready", axi.wready, 1'b0);
        check_b("reset_bvalid", axi.bvalid, 1'b0);
        check_b("reset_rvalid", axi.rvalid, 1'b0);
        check_b("reset_rlast", axi.rlast, 1'b0);
        check_w("reset_rdata", axi.rdata, '0);
        check_b("reset_rid", axi.rid, 1'b0);
        check_b("reset_bid", axi.bid, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        write_burst(1'b1, 30'h40, 0, 0);
        read_burst(1'b1, 30'h40, 0, 0);

        write_burst(1'b0, 30'h1000, 15, 2);
        write_burst(1'b1, 30'h1000, 15, 1);
        read_burst(1'b0, 30'h1000, 15, 0);

        write_burst(1'b1, 30'h4000, 255, 3);
        read_burst(1'b1, 30'h4000, 255, 0);
        read_burst(1'b0, 30'h4000, 7, 1);

        @(negedge clk);
        aw_drive(1'b0, 30'h200, 1);
        ar_drive(1'b1, 30'h200, 1);
        #1;
        check_b("arb1_awready", axi.awready, 1'b1);
        check_b("arb1_arready", axi.arready, 1'b0);
        aw_accept(hs);
        check_b("arb1_ar_held_off", axi.arready, 1'b0);
        w_phase(30'h200, 1, 4, -1, 1'b0);
        ar_accept(hs);
        r_phase(hs, 2, 0);

        @(negedge clk);
        aw_drive(1'b1, 30'h200, 1);
        ar_drive(1'b0, 30'h200, 1);
        #1;
        check_b("arb2_arready", axi.arready, 1'b1);
        check_b("arb2_awready", axi.awready, 1'b0);
        ar_accept(hs);
        check_b("arb2_aw_held_off", axi.awready, 1'b0);
        r_phase(hs, 2, 0);
        aw_accept(hs);
        w_phase(30'h200, 1, 5, -1, 1'b1);
        read_burst(1'b0, 30'h200, 1, 0);

        write_burst(1'b1, 30'h2001_FFD1, 3, 6);
        read_burst(1'b0, 30'h0001_FFC0, 3, 0);
        read_burst(1'b1, 30'h0, 1, 0);

        write_burst(1'b0, 30'h6000, 15, 7);
        @(negedge clk);
        aw_drive(1'b1, 30'h6000, 15);
        aw_accept(hs);
        w_phase(30'h6000, 15, 8, 5, 1'b1);
        #1;
        check_b("post_rst_wready", axi.wready, 1'b0);
        check_b("post_rst_bvalid", axi.bvalid, 1'b0);
        read_burst(1'b1, 30'h6000, 15, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

AXI4 responder backed by on-chip single-port RAM. It terminates the burst traffic that the L2 cache's AXI master port issues toward DDR. It serves as the DDR stand-in for simulation and for FPGA builds without a memory controller. It accepts INCR read and write bursts of up to 256 beats, services one transaction at a time, and always answers OKAY.

## Interface
- ADDR_W, 30: AXI byte-address width; matches the DDR address width.
- DATA_W, 256: AXI data width; matches the MIG bus width. Must be a power of two, at least 32.
- MEM_ADDR_W, 12: RAM depth is 2^MEM_ADDR_W words of DATA_W bits.
- Derived: OFF_W = log2(DATA_W/8).
- Reset: one clock; reset is asynchronous and active-low.

Ports (clock and reset first):
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- axi_awid  in  1  write ID.
- axi_awaddr  in  ADDR_W  write burst start byte address.
- axi_awlen  in  8  write beats minus 1.
- axi_awsize, axi_awburst  in  3, 2  ignored; always full-width INCR.
- axi_awvalid / axi_awready  in / out  1  write-address handshake.
- axi_wdata  in  DATA_W  write data.
- axi_wstrb  in  DATA_W/8  byte enables.
- axi_wlast  in  1  ignored; the beat count comes from awlen.
- axi_wvalid / axi_wready  in / out  1  write-data handshake.
- axi_bid  out  1  echoes the latched awid.
- axi_bresp  out  2  constant 2'b00.
- axi_bvalid / axi_bready  out / in  1  write-response handshake.
- axi_arid  in  1  read ID.
- axi_araddr  in  ADDR_W  read burst start byte address.
- axi_arlen  in  8  read beats minus 1.
- axi_arsize, axi_arburst  in  3, 2  ignored.
- axi_arvalid / axi_arready  in / out  1  read-address handshake.
- axi_rid  out  1  echoes the latched arid.
- axi_rdata  out  DATA_W  read data.
- axi_rresp  out  2  constant 2'b00.
- axi_rlast  out  1  marks the final read beat.
- axi_rvalid / axi_rready  out / in  1  read-data handshake.

## Operation
- State machine: IDLE, WDATA, WRESP, READ.
- Word address = addr[OFF_W +: MEM_ADDR_W]. Upper address bits and the low OFF_W bits are dropped.
- Word address increments by 1 per beat and wraps modulo 2^MEM_ADDR_W.
- Beat counter is 8 bits, loaded with len, and decremented per accepted beat. The last beat is the beat accepted when the counter equals 0.
- IDLE: axi_awready and axi_arready are combinationally asserted for the selected request only.
  - If only awvalid is high, accept the write and go to WDATA.
  - If only arvalid is high, accept the read and go to READ.
  - If both are high, alternate: the class not served last wins. After reset, write has priority.
  - On acceptance, latch ID, word address and len.
- WDATA: axi_wready = 1.
  - Each wvalid & wready writes wdata to RAM with byte enables wstrb in the same cycle.
  - On the last beat, go to WRESP.
  - wlast is not checked.
- WRESP: axi_bvalid = 1 with bid latched. On bready, go to IDLE.
- READ: synchronous RAM feeding a 2-entry output skid buffer.
  - Delivers one beat per cycle while rready = 1.
  - axi_rlast = 1 on the beat where the remaining count is 0.
  - When the last beat handshakes, go to IDLE. No prefetch past len.
- Write data beats arriving before their AW handshake are not accepted: wready = 0 outside WDATA.

## Timing
- Reset values: awready, arready, wready, bvalid, rvalid, rlast = 0; rdata, rid, bid = 0; priority = write.
- RAM contents are not cleared by reset.
- Reset asserted mid-burst aborts the transaction immediately. The FSM returns to IDLE. RAM writes already performed are kept.
- AW handshake at cycle T: wready = 1 from T+1.
- Last W beat at cycle T: bvalid = 1 at T+1.
- bready handshake at cycle T: IDLE at T+1; a new AW or AR can be accepted at T+1.
- AR handshake at cycle T: first rvalid at T+2.
- With rready held high, beat k appears at T+2+k.
- When rready is low, rdata, rlast and rvalid hold stable.
- After rready returns high, throughput is again one beat per cycle with no lost or duplicated beats.
- awlen/arlen = 255 gives exactly 256 beats. len = 0 gives a single beat, with rlast on the first beat.

## Test plan
- Single write then read: AW addr 0x40, len 0, wdata 0xA5 pattern, wstrb all-ones. Expect bresp 00 and bid echoed. AR addr 0x40, len 0 returns the same data with rlast = 1 and first rvalid 2 cycles after AR.
- 16-beat burst: write at 0x1000, len 15, beat i = i, wstrb 0x0000000F on odd beats. Read back 16 beats. Expect even beats full and odd beats with only the low 4 bytes updated. rlast only on beat 15.
- Backpressure: 8-beat read with rready toggling 1,0,0,1,... Expect exactly 8 beats in order, data stable while stalled, no duplicates.
- Simultaneous requests: awvalid and arvalid both high in IDLE after reset. Expect write first, then the read. Repeat with both high again; expect read served before write this time.
- Wrap: write len 3 starting at word 2^MEM_ADDR_W - 2. Expect words top-1, top, 0, 1 written. Read back and confirm.
- Reset mid-burst: drop rst during beat 5 of a 16-beat write. Expect all handshake outputs 0 during reset and IDLE afterwards. Beats 0-4 persist in RAM; beats 5-15 are absent.
